fetch_queue: RTL and testbench



---
 rtl/fetch_queue_if.sv | 67 ++++++
 rtl/fetch_queue.sv | 187 ++++++++++++++++++
 tb/tb_fetch_queue.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
//   Groups the fetch-side, execute-side and decode-side signals of fetch_queue.
//
//   Parameter:
//     DEPTH          queue entries; sets the width of count
//
//   Signals (direction as seen by fetch_queue through modport slave):
//     instr_in       in   32  instruction word presented by fetch this cycle
//     pc4_in         in   32  PC+4 of instr_in
//     branch_taken   in    1  one-cycle redirect request from execute
//     branch_target  in   32  redirect address, valid with branch_taken
//     sel_sto        out   1  fetch PC mux select, 1 = load jump_addr
//     jump_addr      out  32  fetch jump-address input
//     dec_valid      out   1  head entry valid
//     dec_ready      in    1  decode accepts head
//     dec_instr      out  32  head instruction
//     dec_pc4        out  32  head PC+4
//     count          out  log2(DEPTH)+1  occupancy
//
//   Modport master is the environment side (fetch, execute, decode).
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   instr_in;
    logic [31:0]   pc4_in;
    logic          branch_taken;
    logic [31:0]   branch_target;
    logic          sel_sto;
    logic [31:0]   jump_addr;
    logic          dec_valid;
    logic          dec_ready;
    logic [31:0]   dec_instr;
    logic [31:0]   dec_pc4;
    logic [CW-1:0] count;

    modport slave (
        input  instr_in,
        input  pc4_in,
        input  branch_taken,
        input  branch_target,
        input  dec_ready,
        output sel_sto,
        output jump_addr,
        output dec_valid,
        output dec_instr,
        output dec_pc4,
        output count
    );

    modport master (
        output instr_in,
        output pc4_in,
        output branch_taken,
        output branch_target,
        output dec_ready,
        input  sel_sto,
        input  jump_addr,
        input  dec_valid,
        input  dec_instr,
        input  dec_pc4,
        input  count
    );
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Consumer-side partner of a fetch stage that has no stall input. Every cycle
//   fetch presents an instruction word and its PC+4; this block either pushes
//   it into a small FIFO for decode or, when it cannot accept, redirects fetch
//   back to the same address so the word is fetched again (replay). It also
//   loads RESET_VECTOR into fetch after reset and redirects fetch on taken
//   branches, flushing the queue.
//
//   Parameters:
//     DEPTH          FIFO entries, power of two, >= 2
//     RESET_VECTOR   first fetch address after reset
//
//   Ports:
//     clk            rising-edge clock
//     rst_n          asynchronous active-low reset
//     io_fq          fetch_queue_if.slave bundle (fetch, execute, decode sides)
//     o_replay_cnt   saturating count of replay cycles     (FETCHQ_STATS_EN)
//     o_flush_cnt    saturating count of branch flushes    (FETCHQ_STATS_EN)
//
//   Optional feature macro: FETCHQ_STATS_EN adds the two statistics counters
//   and their output ports. Without it the ports and counters are absent.
//
//   Priority in RUN each cycle: branch flush, then replay when full and not
//   popping, otherwise push. sel_sto/jump_addr are combinational because
//   fetch samples them on the same edge.
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_queue_if.slave   io_fq
`ifdef FETCHQ_STATS_EN
    ,
    output logic [15:0]    o_replay_cnt,
    output logic [15:0]    o_flush_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        StBoot,
        StRun
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic [31:0]   r_mem_instr [DEPTH];
    logic [31:0]   r_mem_pc4   [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_dec_valid;
    logic          w_pop;
    logic          w_full;
    logic          w_push;
    logic          w_flush;
    logic          w_replay;
    logic          w_sel_sto;
    logic [31:0]   w_jump_addr;

    assign w_dec_valid = (r_count != '0);
    assign w_pop       = w_dec_valid && io_fq.dec_ready;
    assign w_full      = (r_count == FULL_CNT);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StBoot;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and fetch redirect. While reset is held the state sits in
    // StBoot, so fetch keeps loading RESET_VECTOR on every edge.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_sel_sto    = 1'b1;
        w_jump_addr  = RESET_VECTOR;
        w_push       = 1'b0;
        w_flush      = 1'b0;
        w_replay     = 1'b0;

        unique case (r_state)
            StBoot: begin
                // Presented word and branch_taken are ignored here.
                w_state_next = StRun;
            end
            StRun: begin
                if (io_fq.branch_taken) begin
                    w_flush     = 1'b1;
                    w_jump_addr = io_fq.branch_target;
                end else if (w_full && !w_pop) begin
                    // No room: point fetch back at the word it just presented.
                    w_replay    = 1'b1;
                    w_jump_addr = io_fq.pc4_in - 32'd4;
                end else begin
                    w_push      = 1'b1;
                    w_sel_sto   = 1'b0;
                    w_jump_addr = io_fq.pc4_in;
                end
            end
            default: begin
                w_state_next = StBoot;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FIFO storage and pointers. A pop during a flush still completes the
    // decode handshake; the flush simply discards whatever remains.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc4[i]   <= '0;
            end
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem_instr[r_wptr] <= io_fq.instr_in;
                r_mem_pc4[r_wptr]   <= io_fq.pc4_in;
                r_wptr              <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            // Push and pop together (including when full) leave count unchanged.
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

`ifdef FETCHQ_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics, saturating at all-ones.
    // -------------------------------------------------------------------------
    logic [15:0] r_replay_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_replay_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_replay && (r_replay_cnt != 16'hFFFF)) begin
                r_replay_cnt <= r_replay_cnt + 16'd1;
            end
            if (w_flush && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign o_replay_cnt = r_replay_cnt;
    assign o_flush_cnt  = r_flush_cnt;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign io_fq.sel_sto   = w_sel_sto;
    assign io_fq.jump_addr = w_jump_addr;
    assign io_fq.dec_valid = w_dec_valid;
    assign io_fq.dec_instr = r_mem_instr[r_rptr];
    assign io_fq.dec_pc4   = r_mem_pc4[r_rptr];
    assign io_fq.count     = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Bench for fetch_queue. A fetch model holds a PC that loads jump_addr when
//   sel_sto is set and otherwise advances by 4; the word at address A is
//   32'h1000_0000 + A. A queue model receives each accepted word when it is
//   presented and releases it when decode pops, and every cycle the DUT's
//   redirect outputs, occupancy and head entry are compared against it.
//   Directed checks cover the reset sequence, stalls, branches and resets.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH)) fq ();

    // Fetch model
    logic [31:0] pc = 32'hDEAD_0000;
    assign fq.instr_in = 32'h1000_0000 + pc;
    assign fq.pc4_in   = pc + 32'd4;
    always @(posedge clk) pc <= fq.sel_sto ? fq.jump_addr : pc + 32'd4;

`ifdef FETCHQ_STATS_EN
    logic [15:0] replay_cnt;
    logic [15:0] flush_cnt;
`endif

    fetch_queue #(
        .DEPTH        (DEPTH),
        .RESET_VECTOR (RV)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .io_fq        (fq)
`ifdef FETCHQ_STATS_EN
        ,
        .o_replay_cnt (replay_cnt),
        .o_flush_cnt  (flush_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Queue model: {instr, pc4}, front is the head decode should see.
    logic [63:0] m_q[$];
    logic        m_boot     = 1'b1;
    logic [31:0] m_next_pc4 = RV + 32'd4;

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: compare at the falling edge, update the model at the rising
    // edge, return 1 time unit later so the caller can drive new inputs.
    task automatic tick();
        logic        s_rst, s_br, s_rdy, pop, full, exp_sel;
        logic [31:0] s_tgt, s_pc4, s_instr, exp_jump;
        int          sz;
        @(negedge clk);
        s_rst   = rst_n;
        s_br    = fq.branch_taken;
        s_tgt   = fq.branch_target;
        s_rdy   = fq.dec_ready;
        s_pc4   = fq.pc4_in;
        s_instr = fq.instr_in;
        sz      = m_q.size();
        full    = (sz == int'(DEPTH));
        pop     = s_rst && (sz != 0) && s_rdy;

        exp_sel  = 1'b1;
        exp_jump = RV;
        if (s_rst && !m_boot) begin
            if (s_br)              exp_jump = s_tgt;
            else if (full && !pop) exp_jump = s_pc4 - 32'd4;
            else                   exp_sel  = 1'b0;
        end
        check_val("sel_sto", 32'(fq.sel_sto), 32'(exp_sel));
        if (exp_sel) check_val("jump_addr", fq.jump_addr, exp_jump);
        check_val("count", 32'(fq.count), 32'(sz));
        check_val("dec_valid", 32'(fq.dec_valid), 32'(sz != 0));
        if (sz != 0) begin
            check_val("dec_instr", fq.dec_instr, m_q[0][63:32]);
            check_val("dec_pc4", fq.dec_pc4, m_q[0][31:0]);
        end

        @(posedge clk);
        if (!s_rst) begin
            m_boot = 1'b1;
            m_q.delete();
            m_next_pc4 = RV + 32'd4;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (s_br) begin
            m_q.delete();
            m_next_pc4 = s_tgt + 32'd4;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (!(full && !pop)) begin
                // Accepted words must follow program order: no skip, no repeat.
                check_val("order_pc4", s_pc4, m_next_pc4);
                m_q.push_back({s_instr, s_pc4});
                m_next_pc4 = s_pc4 + 32'd4;
            end
        end
        #1;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_dec_valid", 32'(fq.dec_valid), 32'd0);
        check_val("rst_count", 32'(fq.count), 32'd0);
        check_val("rst_dec_instr", fq.dec_instr, 32'd0);
        check_val("rst_dec_pc4", fq.dec_pc4, 32'd0);
        m_boot = 1'b1;
        m_q.delete();
        m_next_pc4 = RV + 32'd4;
    endtask

    initial begin
        fq.branch_taken  = 1'b0;
        fq.branch_target = 32'd0;
        fq.dec_ready     = 1'b1;
        #1;
        assert_reset();
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset release: E0 ends BOOT, RESET_VECTOR word visible from E0+2.
        tick();
        check_val("boot_dec_valid", 32'(fq.dec_valid), 32'd0);
        tick();
        check_val("first_valid", 32'(fq.dec_valid), 32'd1);
        check_val("first_instr", fq.dec_instr, 32'h1000_0000);
        check_val("first_pc4", fq.dec_pc4, 32'h0000_0004);
        tick();
        check_val("second_instr", fq.dec_instr, 32'h1000_0004);
        check_val("second_pc4", fq.dec_pc4, 32'h0000_0008);
        tick();
        check_val("third_instr", fq.dec_instr, 32'h1000_0008);
        check_val("third_pc4", fq.dec_pc4, 32'h0000_000C);

        // Stall: queue fills, then fetch is replayed each cycle.
        fq.dec_ready = 1'b0;
        repeat (8) tick();
        check_val("stall_count", 32'(fq.count), 32'd4);
        check_val("stall_sel", 32'(fq.sel_sto), 32'd1);
        check_val("stall_jump", fq.jump_addr, fq.pc4_in - 32'd4);
        fq.dec_ready = 1'b1;
        repeat (5) tick();
        check_val("stream_count", 32'(fq.count), 32'd4);

        // Branch while full and not popping: branch wins.
        fq.dec_ready = 1'b0;
        tick();
        fq.branch_taken  = 1'b1;
        fq.branch_target = 32'h0000_0200;
        #1;
        check_val("brfull_sel", 32'(fq.sel_sto), 32'd1);
        check_val("brfull_jump", fq.jump_addr, 32'h0000_0200);
        tick();
        fq.branch_taken = 1'b0;
        check_val("brfull_count", 32'(fq.count), 32'd0);

        // Branch with count==3.
        repeat (3) tick();
        check_val("pre_br_count", 32'(fq.count), 32'd3);
        fq.branch_taken  = 1'b1;
        fq.branch_target = 32'h0000_0100;
        tick();
        fq.branch_taken = 1'b0;
        check_val("br_count", 32'(fq.count), 32'd0);
        check_val("br_valid", 32'(fq.dec_valid), 32'd0);
        tick();
        check_val("tgt_valid", 32'(fq.dec_valid), 32'd1);
        check_val("tgt_instr", fq.dec_instr, 32'h1000_0100);
        check_val("tgt_pc4", fq.dec_pc4, 32'h0000_0104);
        tick();
        check_val("pre_rst_count", 32'(fq.count), 32'd2);

        // Reset mid-stream clears at once; refetch from RESET_VECTOR.
        assert_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        fq.dec_ready = 1'b1;
        repeat (2) tick();
        check_val("refetch_instr", fq.dec_instr, 32'h1000_0000);
        check_val("refetch_pc4", fq.dec_pc4, 32'h0000_0004);

        // Random traffic checked against the model.
        for (int i = 0; i < 400; i++) begin
            fq.dec_ready     = ($urandom_range(0, 3) != 0) || (i < 200 && $urandom_range(0, 1) == 0);
            fq.branch_taken  = ($urandom_range(0, 15) == 0);
            fq.branch_target = 32'($urandom_range(0, 1023)) << 2;
            tick();
        end
        fq.branch_taken = 1'b0;

`ifdef FETCHQ_STATS_EN
        assert_reset();
        tick();
        rst_n = 1'b1;
        fq.dec_ready = 1'b0;
        tick();
        repeat (4) tick();
        repeat (3) tick();
        fq.branch_taken  = 1'b1;
        fq.branch_target = 32'h0000_0040;
        repeat (2) tick();
        fq.branch_taken = 1'b0;
        check_val("replay_cnt", 32'(replay_cnt), 32'd3);
        check_val("flush_cnt", 32'(flush_cnt), 32'd2);
        repeat (70005) tick();
        check_val("replay_sat", 32'(replay_cnt), 32'h0000_FFFF);
        check_val("flush_hold", 32'(flush_cnt), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
